// File: rtl/branch_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// branch_hazard_unit_if
//   Bundles the decode/execute-stage fields consumed by branch_hazard_unit and
//   the control responses it returns to the decode-stage control decoder.
//
//   Handshake: jump_start is a level request from the decoder. It is accepted
//   on a rising clock edge only while the unit is idle (busy=0) and no load-use
//   stall is requested in that same cycle. The decoder keeps presenting the
//   same instruction until branch_status returns to 00 after the 10 phase, so
//   no separate ready signal exists; busy doubles as "not ready".
//
//   Signals (master = decode/execute pipeline side, slave = hazard unit):
//     jump_start      m->s  control-transfer instruction in decode
//     id_rs1/id_rs2   m->s  decode-stage source register indices
//     id_uses_rs1/2   m->s  decode instruction actually reads rs1/rs2
//     ex_rd           m->s  execute-stage destination register index
//     ex_mem_read     m->s  execute-stage instruction is a load
//     ex_branch_cond  m->s  comparator result for the branch in EX
//     branch_status   s->m  00 idle/hold, 01 redirect, 10 release
//     take_branch     s->m  latched branch outcome (valid while status==01)
//     want_stall      s->m  load-use stall request
//     kill_decode     s->m  squash the decode-stage slot
//     busy            s->m  branch sequence in progress
// -----------------------------------------------------------------------------
interface branch_hazard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  jump_start;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_cond;
    logic [1:0]            branch_status;
    logic                  take_branch;
    logic                  want_stall;
    logic                  kill_decode;
    logic                  busy;

    modport master (
        output jump_start, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_mem_read, ex_branch_cond,
        input  branch_status, take_branch, want_stall, kill_decode, busy
    );

    modport slave (
        input  jump_start, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_mem_read, ex_branch_cond,
        output branch_status, take_branch, want_stall, kill_decode, busy
    );
endinterface

// File: rtl/branch_hazard_unit.sv
// -----------------------------------------------------------------------------
// branch_hazard_unit
//   Sequences every control-transfer instruction through HOLD (RESOLVE_CYCLES
//   cycles), REDIRECT (1 cycle) and RELEASE (1 cycle), latching the branch
//   comparator result on the last HOLD cycle. Independently raises a
//   combinational load-use stall request while idle.
//
//   Parameters:
//     RESOLVE_CYCLES  cycles spent in HOLD before ex_branch_cond is sampled
//                     (legal range 1..15)
//     REG_ADDR_W      register index width
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     bus          branch_hazard_unit_if slave modport (see interface header)
//     dbg_state_o  current FSM state (0 IDLE, 1 HOLD, 2 REDIRECT, 3 RELEASE)
// -----------------------------------------------------------------------------
module branch_hazard_unit #(
    parameter int RESOLVE_CYCLES = 2,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_hazard_unit_if.slave   bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Counter counts down to zero, so a load of RESOLVE_CYCLES-1 gives exactly
    // RESOLVE_CYCLES cycles in HOLD.
    localparam logic [3:0] CNT_LOAD = 4'(RESOLVE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       take_q,  take_d;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  hazard;

    assign id_rs1 = bus.id_rs1;
    assign id_rs2 = bus.id_rs2;
    assign ex_rd  = bus.ex_rd;

    // Load-use hazard: a load in EX writes a register the decode instruction
    // reads. x0 is hard-wired zero, so it never needs a stall.
    assign hazard = bus.ex_mem_read
                 && (ex_rd != '0)
                 && ((bus.id_uses_rs1 && (id_rs1 == ex_rd))
                  || (bus.id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            take_q  <= take_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        take_d            = take_q;
        bus.branch_status = 2'b00;
        bus.kill_decode   = 1'b0;
        bus.want_stall    = 1'b0;
        bus.busy          = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                bus.busy       = 1'b0;
                // Stall is only meaningful here: outside IDLE the branch
                // sequence already holds decode.
                bus.want_stall = hazard;
                // A simultaneous stall wins; jump_start is re-sampled next cycle.
                if (bus.jump_start && !hazard) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    take_d  = bus.ex_branch_cond;
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                bus.branch_status = 2'b01;
                bus.kill_decode   = 1'b1;
                state_d           = ST_RELEASE;
            end
            ST_RELEASE: begin
                bus.branch_status = 2'b10;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.take_branch = take_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
module tb_branch_hazard_unit;

    localparam int RC = 2;
    localparam int AW = 5;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    branch_hazard_unit_if #(.REG_ADDR_W(AW)) bus ();

    branch_hazard_unit #(
        .RESOLVE_CYCLES(RC),
        .REG_ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // exp_q holds the branch_status value expected in each remaining cycle of
    // the current control-transfer sequence; empty means idle.
    logic [1:0] exp_q[$];
    logic       take_m;
    int         checks;
    int         errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic hazard_m(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                      input logic u1, input logic u2,
                                      input logic [AW-1:0] rd, input logic mr);
        return mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive inputs after the falling edge, check outputs, then let
    // the rising edge happen and advance the reference model.
    task automatic step(input logic js, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic mr, input logic cond);
        logic [1:0] exp_st;
        logic       hz;
        @(negedge clk);
        bus.jump_start     = js;
        bus.id_rs1         = rs1;
        bus.id_rs2         = rs2;
        bus.id_uses_rs1    = u1;
        bus.id_uses_rs2    = u2;
        bus.ex_rd          = rd;
        bus.ex_mem_read    = mr;
        bus.ex_branch_cond = cond;
        #1;
        hz     = hazard_m(rs1, rs2, u1, u2, rd, mr);
        exp_st = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
        check("branch_status", 32'(bus.branch_status), 32'(exp_st));
        check("take_branch",   32'(bus.take_branch),   32'(take_m));
        check("want_stall",    32'(bus.want_stall),    32'(exp_q.size() == 0 && hz));
        check("kill_decode",   32'(bus.kill_decode),   32'(exp_st == 2'b01));
        check("busy",          32'(bus.busy),          32'(exp_q.size() > 0));
        @(posedge clk);
        if (exp_q.size() == 0) begin
            if (js && !hz) begin
                for (int i = 0; i < RC; i++) exp_q.push_back(2'b00);
                exp_q.push_back(2'b01);
                exp_q.push_back(2'b10);
            end
        end else begin
            // Last HOLD cycle is the one just before REDIRECT/RELEASE remain.
            if (exp_q.size() == 3) take_m = cond;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic idle_step(input logic cond);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, cond);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.jump_start  = 1'b1;
        bus.ex_mem_read = 1'b0;
        rst_n           = 1'b0;
        #1;
        exp_q.delete();
        take_m = 1'b0;
        check("rst_status", 32'(bus.branch_status), 32'd0);
        check("rst_take",   32'(bus.take_branch),   32'd0);
        check("rst_stall",  32'(bus.want_stall),    32'd0);
        check("rst_kill",   32'(bus.kill_decode),   32'd0);
        check("rst_busy",   32'(bus.busy),          32'd0);
        @(negedge clk);
        bus.jump_start = 1'b0;
        rst_n          = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        take_m = 1'b0;
        rst_n  = 1'b0;
        bus.jump_start     = 1'b1;
        bus.id_rs1         = '0;
        bus.id_rs2         = '0;
        bus.id_uses_rs1    = 1'b0;
        bus.id_uses_rs2    = 1'b0;
        bus.ex_rd          = '0;
        bus.ex_mem_read    = 1'b0;
        bus.ex_branch_cond = 1'b0;

        apply_reset();
        idle_step(1'b0);

        // Taken branch: condition is high only in the sampling cycle.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle_step(1'b0);
        idle_step(1'b1);
        idle_step(1'b0);
        idle_step(1'b0);
        idle_step(1'b0);

        // Not-taken branch: condition is low only in the sampling cycle.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle_step(1'b1);
        idle_step(1'b0);
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);

        // Load-use cases.
        step(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        step(1'b0, 5'd1, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        step(1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);

        // Stall beats jump; next cycle the hazard is gone and HOLD is entered.
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        // Hazard inputs during the sequence must not stall.
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
        idle_step(1'b1);
        idle_step(1'b0);
        idle_step(1'b0);
        idle_step(1'b0);

        // Reset while in REDIRECT: outputs drop at once, no release phase.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        @(negedge clk);
        bus.jump_start = 1'b0;
        #1;
        check("pre_rst_redirect", 32'(bus.branch_status), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        take_m = 1'b0;
        check("mid_rst_status", 32'(bus.branch_status), 32'd0);
        check("mid_rst_kill",   32'(bus.kill_decode),   32'd0);
        check("mid_rst_busy",   32'(bus.busy),          32'd0);
        check("mid_rst_take",   32'(bus.take_branch),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step(1'b0);
        idle_step(1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                 AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
